// File: rtl/imem_seq_pkg.sv
// Shared types and helpers for the instruction-memory sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package imem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    typedef enum logic {
        MODE_READ = 1'b0,
        MODE_LOAD = 1'b1
    } seq_mode_e;

    // Byte distance between consecutive instruction words.
    function automatic int unsigned word_stride(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/imem_lat_pipe.sv
// Read-latency tracker: delays the read-enable strobe by DEPTH cycles.
// Latency: vld_o follows vld_i by exactly DEPTH clock cycles.
// Backpressure: none; the pipe always advances.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset, flushes every stage
//   vld_i  - a read address is being issued this cycle
//   vld_o  - read data for an address issued DEPTH cycles ago is on the bus
//   busy_o - at least one read is still in flight
module imem_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    output logic vld_o,
    output logic busy_o
);

    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | DEPTH'(vld_i);
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign busy_o = |vld_q;

endmodule

// File: rtl/imem_sequencer.sv
// Sequencer that loads a program into, or reads a run of words from, an instruction memory.
// Latency: write issued 1 cycle after a beat is accepted; read data returned RD_LAT+1 cycles after its address.
// Backpressure: LOAD beats use wvalid_i/wready_o; READ issues one address per cycle with no stalls.
//
// Ports:
//   clk_i, rst_i                 - clock and synchronous active-high reset
//   start_i, mode_i, len_i       - run request (sampled only in IDLE); len_i clamped to NUM_WORDS
//   wdata_i, wvalid_i, wready_o  - program word stream for LOAD runs
//   address_o, IWR_EN_o, IR_EN_o - memory address and write/read strobes
//   DATA_o, DATA_i               - memory write data / read data (read data RD_LAT cycles after address)
//   rdata_o, rvalid_o            - captured read word, valid for one cycle
//   busy_o, done_o               - run in progress / one-cycle end-of-run pulse
module imem_sequencer
    import imem_seq_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_WORDS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           mode_i,
    input  logic [$clog2(NUM_WORDS+1)-1:0] len_i,
    input  logic [DATA_W-1:0]              wdata_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [ADDR_W-1:0]              address_o,
    output logic                           IWR_EN_o,
    output logic                           IR_EN_o,
    output logic [DATA_W-1:0]              DATA_o,
    input  logic [DATA_W-1:0]              DATA_i,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           rvalid_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int                LEN_W   = $clog2(NUM_WORDS + 1);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(word_stride(DATA_W));
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(NUM_WORDS);

    // Address of word k; arithmetic is ADDR_W bits wide so it wraps silently.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [LEN_W-1:0] k);
        return BASE_ADDR + ADDR_W'(k) * STRIDE;
    endfunction

    seq_state_e         state_q;
    logic [LEN_W-1:0]   idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdat_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               iwr_q;
    logic               ir_q;
    logic               wready_q;
    logic               rvalid_q;
    logic               done_q;
    logic               pipe_vld;
    logic               pipe_busy;

    always_comb begin
        len_d = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    end

    // The pipe tracks the registered read strobe, so pipe_vld lines up with
    // the cycle in which memory presents the data for that address.
    imem_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (ir_q),
        .vld_o  (pipe_vld),
        .busy_o (pipe_busy)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            addr_q   <= BASE_ADDR;
            wdat_q   <= '0;
            rdata_q  <= '0;
            iwr_q    <= 1'b0;
            ir_q     <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            iwr_q    <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= pipe_vld;
            if (pipe_vld) begin
                rdata_q <= DATA_i;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q <= len_d;
                        idx_q <= '0;
                        if (len_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (seq_mode_e'(mode_i) == MODE_LOAD) begin
                            state_q  <= S_LOAD;
                            wready_q <= 1'b1;
                        end else begin
                            // Word 0 goes out on the very first READ cycle.
                            state_q <= S_READ;
                            ir_q    <= 1'b1;
                            addr_q  <= word_addr('0);
                            idx_q   <= LEN_W'(1);
                        end
                    end
                end

                S_LOAD: begin
                    if (wready_q) begin
                        if (wvalid_i) begin
                            iwr_q  <= 1'b1;
                            addr_q <= word_addr(idx_q);
                            wdat_q <= wdata_i;
                            idx_q  <= idx_q + LEN_W'(1);
                            if (idx_q + LEN_W'(1) == len_q) begin
                                wready_q <= 1'b0;
                            end
                        end
                    end else begin
                        // Last write is on the bus this cycle.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end

                S_READ: begin
                    if (idx_q == len_q) begin
                        state_q <= S_DRAIN;
                        ir_q    <= 1'b0;
                    end else begin
                        addr_q <= word_addr(idx_q);
                        idx_q  <= idx_q + LEN_W'(1);
                    end
                end

                S_DRAIN: begin
                    // Once the pipe is empty the final rvalid_o is already out.
                    if (!pipe_busy) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wready_o  = wready_q;
    assign address_o = addr_q;
    assign IWR_EN_o  = iwr_q;
    assign IR_EN_o   = ir_q;
    assign DATA_o    = wdat_q;
    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;

endmodule
